// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: multiply/divide op codes, MDU FSM states
// and a constant log2 helper for deriving counter widths.
package mips_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Ceiling log2; returns at least 1 so a counter is never zero bits wide.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative one-bit-per-cycle multiply/divide unit owning HI/LO. Multiply and
// divide share one 2W shift register and iteration counter.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  hi_wr,
    input  logic                  lo_wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned W         = DATA_WIDTH;
    localparam int unsigned CNT_WIDTH = log2(DATA_WIDTH);

    mdu_state_e           state_q, state_d;
    mdu_op_e              op_q, op_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         dvs_q, dvs_d;
    logic [W-1:0]         a_q, a_d;
    logic                 sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 in_signed;
    logic [W-1:0]         a_mag, b_mag;
    logic [W:0]           mul_sum;
    logic [W:0]           rem_sh;
    logic [W:0]           div_diff;
    logic [2*W-1:0]       prod_fix;
    logic [W-1:0]         quo, rem;

    always_comb begin
        in_signed = ~op[0];
        a_mag     = (in_signed && a[W-1]) ? -a : a;
        b_mag     = (in_signed && b[W-1]) ? -b : b;

        // Multiply: acc = {partial product, remaining multiplier bits}.
        mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? dvs_q : '0)};
        // Divide: acc = {remainder, remaining dividend bits / quotient bits}.
        rem_sh    = {acc_q[2*W-1:W], acc_q[W-1]};
        div_diff  = rem_sh - {1'b0, dvs_q};

        prod_fix  = (op_q == MDU_MULT && (sa_q ^ sb_q)) ? -acc_q : acc_q;
        quo       = (op_q == MDU_DIV && (sa_q ^ sb_q)) ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem       = (op_q == MDU_DIV && sa_q) ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = mdu_op_e'(op);
                    a_d     = a;
                    sa_d    = a[W-1];
                    sb_d    = b[W-1];
                    acc_d   = {{W{1'b0}}, a_mag};
                    dvs_d   = b_mag;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    if (hi_wr) hi_d = wdata;
                    if (lo_wr) lo_d = wdata;
                end
            end
            S_RUN: begin
                if (op_q[1]) begin
                    if (div_diff[W]) acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
                    else             acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                end else begin
                    acc_d = {mul_sum, acc_q[W-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_WIDTH'(W-1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!op_q[1]) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (dvs_q == '0) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = rem;
                    lo_d = quo;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= MDU_MULT;
            cnt_q   <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != S_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic
// model of MIPS MULT/MULTU/DIV/DIVU and HI/LO write semantics.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a, b, wdata;
    logic          hi_wr, lo_wr;
    logic [W-1:0]  hi, lo;
    logic          busy, done;

    int unsigned   n_checks = 0;
    int unsigned   n_pass   = 0;
    logic [W-1:0]  exp_hi   = '0;
    logic [W-1:0]  exp_lo   = '0;

    mult_div_unit #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_wr (hi_wr),
        .lo_wr (lo_wr),
        .wdata (wdata),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Returns {HI, LO} as MIPS defines it for this unit.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                               input logic [W-1:0] y);
        longint sx, sy, q, r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = {32'b0, x} * {32'b0, y};
            2'd2: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'h0, 32'h8000_0000};
                else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else        p = {x % y, x / y};
            end
        endcase
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit wr_with_start, input bit interfere);
        logic [63:0] r;
        int unsigned cyc;
        int unsigned early_done;
        r     = ref_result(o, x, y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        wdata = $urandom;
        hi_wr = wr_with_start;
        lo_wr = wr_with_start;
        tick();
        start = 1'b0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        check("busy_after_start", {63'b0, busy}, 64'd1);
        cyc        = 1;
        early_done = 0;
        while (cyc < 100) begin
            if (cyc == 5 || cyc == 20)
                check("hilo_held", {hi, lo}, {exp_hi, exp_lo});
            if (cyc == 5 && interfere) begin
                start = 1'b1;
                op    = 2'd2;
                a     = $urandom;
                b     = $urandom;
                hi_wr = 1'b1;
                lo_wr = 1'b1;
                wdata = $urandom;
            end
            tick();
            start = 1'b0;
            hi_wr = 1'b0;
            lo_wr = 1'b0;
            if (!busy) break;
            if (done) early_done++;
            cyc++;
        end
        check("busy_cycles", 64'(cyc), 64'(W + 1));
        check("done_early", 64'(early_done), 64'd0);
        check("done_pulse", {63'b0, done}, 64'd1);
        check("result", {hi, lo}, r);
        {exp_hi, exp_lo} = r;
        tick();
        check("done_clear", {63'b0, done}, 64'd0);
    endtask

    task automatic write_hilo(input bit h, input bit l, input logic [W-1:0] d);
        hi_wr = h;
        lo_wr = l;
        wdata = d;
        tick();
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        check("mt_write", {hi, lo}, {exp_hi, exp_lo});
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return W'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int unsigned dones;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wdata = '0;
        repeat (2) tick();
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy_done", {62'b0, busy, done}, 64'd0);
        rst = 1'b0;
        tick();

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("multu_max", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        check("mult_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
        run_op(2'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        check("divu_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        check("divu_100_7", {hi, lo}, {32'd2, 32'd14});

        run_op(2'd1, 32'd3, 32'd4, 1'b1, 1'b1);
        check("multu_interfered", {hi, lo}, {32'd0, 32'd12});
        write_hilo(1'b1, 1'b1, 32'hA5A5_A5A5);
        write_hilo(1'b1, 1'b0, 32'h1234_5678);
        write_hilo(1'b0, 1'b1, 32'h0BAD_F00D);

        op    = 2'd3;
        a     = $urandom;
        b     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy_done", {62'b0, busy, done}, 64'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (done) dones++;
        end
        check("abort_no_done", 64'(dones), 64'd0);
        run_op(2'd1, 32'd2, 32'd3, 1'b0, 1'b0);
        check("after_abort", {32'd0, lo}, 64'd6);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_hilo(1'($urandom), 1'($urandom), $urandom);
            run_op(2'($urandom), pick_operand(), pick_operand(),
                   1'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1);
    end

endmodule
